// File: rtl/sha256_digest_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_digest_streamer_if
// Brief    : Digest capture inputs and valid/ready byte stream of the SHA-256 egress streamer.
// Revision : 1.0
// ============================================================================
interface sha256_digest_streamer_if;
    logic [255:0] digest_in;
    logic         digest_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_last;
    logic         tx_ready;
    logic         busy;
    logic         overrun;

    modport master (
        input  digest_in,
        input  digest_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid,
        output tx_last,
        output busy,
        output overrun
    );

    modport slave (
        output digest_in,
        output digest_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        input  busy,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/sha256_digest_streamer.sv
`default_nettype none
// ============================================================================
// Module   : sha256_digest_streamer
// Brief    : Captures a SHA-256 digest on a done edge and streams it as raw or hex bytes.
// Revision : 1.0
// ============================================================================
module sha256_digest_streamer #(
    parameter bit HEX_ASCII   = 1'b1,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    sha256_digest_streamer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_TRAIL = 2'd2
    } state_t;

    localparam bit         c_USE_CRLF    = HEX_ASCII && APPEND_CRLF;
    localparam logic [6:0] c_DIGEST_LEN  = HEX_ASCII ? 7'd64 : 7'd32;
    localparam logic [6:0] c_DIGEST_LAST = c_DIGEST_LEN - 7'd1;
    localparam logic [6:0] c_FRAME_LAST  = c_USE_CRLF ? 7'd65 : c_DIGEST_LAST;

    state_t       r_state;
    state_t       w_state_next;
    logic [255:0] r_shift;
    logic [6:0]   r_cnt;
    logic         r_prev;
    logic         r_pend;
    logic         r_overrun;

    logic         w_rise;
    logic         w_valid;
    logic         w_accept;
    logic         w_final;
    logic         w_capture;
    logic [3:0]   w_nib;
    logic [7:0]   w_hex;
    logic [7:0]   w_data;
    logic         w_last;

    assign w_rise    = bus.digest_valid & ~r_prev;
    assign w_valid   = (r_state != S_IDLE);
    assign w_accept  = w_valid & bus.tx_ready;
    assign w_final   = w_accept & w_last;
    // A rise landing on the final handshake is a legal capture, not an overrun.
    assign w_capture = w_rise & ((r_state == S_IDLE) | w_final);

    assign w_nib = r_shift[255:252];
    assign w_hex = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h57 + {4'h0, w_nib});

    always_comb begin
        w_data = 8'h00;
        w_last = 1'b0;
        case (r_state)
            S_SEND: begin
                w_data = HEX_ASCII ? w_hex : r_shift[255:248];
                w_last = !c_USE_CRLF && (r_cnt == c_DIGEST_LAST);
            end
            S_TRAIL: begin
                w_data = (r_cnt == c_DIGEST_LEN) ? 8'h0D : 8'h0A;
                w_last = (r_cnt == c_FRAME_LAST);
            end
            default: begin
                w_data = 8'h00;
                w_last = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rise || r_pend) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (w_accept && (r_cnt == c_DIGEST_LAST)) begin
                    w_state_next = c_USE_CRLF ? S_TRAIL : S_IDLE;
                end
            end
            S_TRAIL: begin
                if (w_final) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_prev    <= 1'b0;
            r_pend    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_prev <= bus.digest_valid;
            // A capture on the final handshake waits one idle cycle before sending.
            r_pend <= w_rise & w_final;
            if (w_capture) begin
                r_shift <= bus.digest_in;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 7'd1;
                if (r_state == S_SEND) begin
                    r_shift <= HEX_ASCII ? {r_shift[251:0], 4'h0} : {r_shift[247:0], 8'h00};
                end
            end
            if (w_rise && w_valid && !w_final) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.tx_data  = w_data;
    assign bus.tx_valid = w_valid;
    assign bus.tx_last  = w_last;
    assign bus.busy     = w_valid;
    assign bus.overrun  = r_overrun;
endmodule
`default_nettype wire
